resolution_text_renderer: RTL and testbench
===========================================

Name: resolution_text_renderer

Overview:
- Reader side of the per-mode resolution-label character ROM.
- Drives the ROM row address ahead of the beam, captures each returned bitmap line into a shift register, and serializes it MSB-first into a 1-bit overlay pixel stream.
- Sits between the video timing generator (hpos/vpos/de) and the pixel mux that composites the label onto the test pattern.
- Mode-agnostic: label content comes entirely from the ROM, which is keyed by the current videoMode outside this block.

Parameters:
- LINE_BITS, 256: width of one ROM line (equals RESLINE_SIZE); pixels per label row at SCALE 1.
- ROWS, 16: label height in ROM rows (rom_addr range 0..ROWS-1).
- X_START, 64: first label pixel column; must be ≥ 3.
- Y_START, 32: first label pixel line.
- SCALE_LOG2, 0: label magnification 2^SCALE_LOG2 in both axes (0..2).

Ports:
- clock  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- hpos  in  12  current pixel column from timing generator.
- vpos  in  12  current line from timing generator.
- de_in  in  1  active-video enable for hpos/vpos.
- rom_addr  out  4  row address to the resolution ROM; ROM read latency is 1 clock.
- rom_q  in  LINE_BITS  ROM line data, valid 1 clock after rom_addr.
- de_out  out  1  de_in delayed 1 clock.
- text_on  out  1  overlay pixel for the pixel presented on hpos one clock earlier.

Behaviour:
- Reset (async, resetn low): rom_addr=0, de_out=0, text_on=0, shift register=0, counters=0, state=IDLE. Release is synchronous to clock.
- row_window = (vpos ≥ Y_START) and (vpos < Y_START + ROWS<<SCALE_LOG2).
- row = (vpos − Y_START) >> SCALE_LOG2, truncated to 4 bits.
- FSM, evaluated per clock:
  - IDLE: if row_window and hpos == X_START−3, register rom_addr=row and go FETCH.
  - FETCH (hpos = X_START−2): ROM samples the address; go LOAD.
  - LOAD (hpos = X_START−1): shift register <= rom_q; bit_cnt=0; scale_cnt=0; go SHIFT.
  - SHIFT: current pixel = shift register MSB.
    - scale_cnt increments each clock. When it reaches 2^SCALE_LOG2−1, scale_cnt wraps to 0, the register shifts left by 1 (zero fill) and bit_cnt increments.
    - When bit_cnt reaches LINE_BITS−1 and the scale wraps, go DONE.
  - DONE: hold until hpos == 0, then go IDLE.
- Abort: hpos == 0 in any non-IDLE state forces IDLE and clears the shift register. This covers a line shorter than the label.
- Pixel output:
  - text_on <= (state==SHIFT) & MSB & de_in; registered, so latency is exactly 1 clock.
  - de_out <= de_in.
- Progress depends only on hpos/vpos. de_in low mid-line masks text_on but does not pause the shift.
- rom_addr holds its last value outside fetches. It changes only at the IDLE→FETCH transition.
- Last label line is vpos = Y_START + (ROWS<<SCALE_LOG2) − 1. Lines outside row_window produce text_on=0 for the whole line.
- vpos wrap to 0 needs no special handling; row_window is simply false.
- Reset asserted mid-SHIFT: text_on drops to 0 immediately (async). After release the FSM restarts cleanly at the next qualifying line.
- hpos jumping (non-monotonic) while in SHIFT is ignored until hpos == 0.

Test Plan:
- Defaults; ROM row 0 = 0x8000…0001; vpos=32, hpos sweeping.
  - Required: rom_addr=0 issued at hpos=61.
  - Required: text_on=1 in the clocks after hpos=64 and hpos=319; 0 for all other hpos.
- SCALE_LOG2=1; ROM row 3 = 0xC000…0; vpos=38 (row 3).
  - Required: rom_addr=3.
  - Required: text_on high for exactly 4 consecutive clocks, following hpos=64..67.
- vpos=31 and vpos=48 (defaults); ROM all-ones.
  - Required: no rom_addr update; text_on=0 for the full line.
- de_in forced low for hpos 100..109 during SHIFT; ROM all-ones.
  - Required: text_on=0 for exactly those 10 pixels, 1 elsewhere in 64..319.
  - Required: the last 1 follows hpos=319, so shift alignment is unchanged.
- hpos wraps to 0 at hpos=200 mid-SHIFT.
  - Required: FSM returns to IDLE and text_on=0 from the next clock.
  - Required: the next line re-fetches at hpos=61.
- resetn pulsed low at hpos=150 during SHIFT.
  - Required: text_on, de_out and rom_addr go 0 asynchronously.
  - Required: after release, the next qualifying line renders normally.

Source files
------------

// File: rtl/resolution_text_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : resolution_text_renderer
//  Description : Fetches resolution-label ROM lines ahead of the beam and
//                serializes them MSB-first into a 1-bit overlay pixel stream.
//  Revision    : 1.0  initial release
// ============================================================================
module resolution_text_renderer #(
  parameter int LINE_BITS  = 256,
  parameter int ROWS       = 16,
  parameter int X_START    = 64,
  parameter int Y_START    = 32,
  parameter int SCALE_LOG2 = 0
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [11:0]          hpos,
  input  logic [11:0]          vpos,
  input  logic                 de_in,
  output logic [3:0]           rom_addr,
  input  logic [LINE_BITS-1:0] rom_q,
  output logic                 de_out,
  output logic                 text_on
);

  localparam int c_bit_w = $clog2(LINE_BITS);
  localparam int c_sc_w  = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int c_sc_max = (1 << SCALE_LOG2) - 1;
  localparam logic [12:0] c_y_lo = 13'(Y_START);
  localparam logic [12:0] c_y_hi = 13'(Y_START + (ROWS << SCALE_LOG2));
  localparam logic [11:0] c_fetch_h = 12'(X_START - 3);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_LOAD  = 3'd2;
  localparam logic [2:0] c_SHIFT = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]           r_state;
  logic [LINE_BITS-1:0] r_shift;
  logic [c_bit_w-1:0]   r_bit_cnt;
  logic [c_sc_w-1:0]    r_scale_cnt;

  logic       w_row_window;
  logic [3:0] w_row;
  logic       w_scale_wrap;
  logic       w_last_bit;
  logic       w_line_start;

  assign w_row_window = ({1'b0, vpos} >= c_y_lo) && ({1'b0, vpos} < c_y_hi);
  assign w_row        = 4'((vpos - 12'(Y_START)) >> SCALE_LOG2);
  assign w_scale_wrap = (r_scale_cnt == c_sc_w'(c_sc_max));
  assign w_last_bit   = (r_bit_cnt == c_bit_w'(LINE_BITS - 1));
  assign w_line_start = (hpos == 12'd0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= c_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_scale_cnt <= '0;
      rom_addr    <= '0;
      de_out      <= 1'b0;
      text_on     <= 1'b0;
    end else begin
      de_out  <= de_in;
      text_on <= (r_state == c_SHIFT) & r_shift[LINE_BITS-1] & de_in;

      // A new line always resynchronizes the reader, even mid-label.
      if ((r_state != c_IDLE) && w_line_start) begin
        r_state <= c_IDLE;
        r_shift <= '0;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (w_row_window && (hpos == c_fetch_h)) begin
              rom_addr <= w_row;
              r_state  <= c_FETCH;
            end
          end
          c_FETCH: r_state <= c_LOAD;
          c_LOAD: begin
            r_shift     <= rom_q;
            r_bit_cnt   <= '0;
            r_scale_cnt <= '0;
            r_state     <= c_SHIFT;
          end
          c_SHIFT: begin
            // Progress is tied to the pixel clock, so de_in gaps never skew alignment.
            if (w_scale_wrap) begin
              r_scale_cnt <= '0;
              r_shift     <= {r_shift[LINE_BITS-2:0], 1'b0};
              r_bit_cnt   <= r_bit_cnt + 1'b1;
              if (w_last_bit) begin
                r_state <= c_DONE;
              end
            end else begin
              r_scale_cnt <= r_scale_cnt + 1'b1;
            end
          end
          c_DONE: r_state <= c_DONE;
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_resolution_text_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_resolution_text_renderer
//  Description : Directed self-checking bench for resolution_text_renderer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_resolution_text_renderer;

  logic         clock = 1'b0;
  logic         resetn;
  logic [11:0]  hpos;
  logic [11:0]  vpos;
  logic         de_in;
  logic [3:0]   rom_addr_a, rom_addr_b;
  logic [255:0] rom_q_a, rom_q_b;
  logic         de_out_a, de_out_b;
  logic         text_on_a, text_on_b;

  logic [255:0] rom_a [16];
  logic [255:0] rom_b [16];

  logic         tx_a   [0:1023];
  logic         tx_b   [0:1023];
  logic         de_o_a [0:1023];
  logic [3:0]   addr_a [0:1023];
  logic [3:0]   addr_b [0:1023];
  logic         expv   [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // ROM models with one clock of read latency
  always @(posedge clock) begin
    rom_q_a <= rom_a[rom_addr_a];
    rom_q_b <= rom_b[rom_addr_b];
  end

  resolution_text_renderer dut_a (
    .clock    (clock),
    .resetn   (resetn),
    .hpos     (hpos),
    .vpos     (vpos),
    .de_in    (de_in),
    .rom_addr (rom_addr_a),
    .rom_q    (rom_q_a),
    .de_out   (de_out_a),
    .text_on  (text_on_a)
  );

  resolution_text_renderer #(.SCALE_LOG2(1)) dut_b (
    .clock    (clock),
    .resetn   (resetn),
    .hpos     (hpos),
    .vpos     (vpos),
    .de_in    (de_in),
    .rom_addr (rom_addr_b),
    .rom_q    (rom_q_b),
    .de_out   (de_out_b),
    .text_on  (text_on_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_set(input int lo, input int hi, input logic val);
    for (int h = lo; h <= hi; h++) expv[h] = val;
  endtask

  task automatic cmp_line(input string tag, input int which, input int hlen);
    int m;
    logic t;
    m = 0;
    for (int h = 0; h < hlen; h++) begin
      t = (which == 0) ? tx_a[h] : tx_b[h];
      if (t !== expv[h]) m++;
    end
    check(tag, m, 0);
  endtask

  task automatic addr_changes(input string tag, input int hlen, input logic [3:0] hold);
    int m;
    m = 0;
    for (int h = 0; h < hlen; h++) if (addr_a[h] !== hold) m++;
    check(tag, m, 0);
  endtask

  // One video line: hpos 0..hlen-1, de low at hpos 0 and over [de_lo, de_hi].
  task automatic run_line(input int v, input int hlen, input int de_lo, input int de_hi,
                          input int rst_at);
    for (int h = 0; h < hlen; h++) begin
      @(negedge clock);
      hpos  = 12'(h);
      vpos  = 12'(v);
      de_in = (h != 0) && !(h >= de_lo && h <= de_hi);
      if (h == rst_at) begin
        #2;
        check("pre_rst_text_on", text_on_a, 1);
        check("pre_rst_de_out", de_out_a, 1);
        check("pre_rst_rom_addr", rom_addr_a, 4'(v - 32));
        resetn = 1'b0;
        #1;
        check("rst_text_on_async", text_on_a, 0);
        check("rst_de_out_async", de_out_a, 0);
        check("rst_rom_addr_async", rom_addr_a, 0);
      end
      if (rst_at >= 0 && h == rst_at + 3) resetn = 1'b1;
      @(posedge clock);
      #1;
      tx_a[h]   = text_on_a;
      tx_b[h]   = text_on_b;
      de_o_a[h] = de_out_a;
      addr_a[h] = rom_addr_a;
      addr_b[h] = rom_addr_b;
    end
  endtask

  initial begin
    resetn = 1'b0;
    hpos   = '0;
    vpos   = '0;
    de_in  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rom_a[i] = {256{1'b1}};
      rom_b[i] = '0;
    end
    rom_a[0] = {1'b1, 254'b0, 1'b1};
    rom_b[3] = {2'b11, 254'b0};

    repeat (3) @(posedge clock);
    #1;
    check("reset_rom_addr", rom_addr_a, 0);
    check("reset_de_out", de_out_a, 0);
    check("reset_text_on", text_on_a, 0);
    check("reset_rom_addr_b", rom_addr_b, 0);
    check("reset_de_out_b", de_out_b, 0);
    check("reset_text_on_b", text_on_b, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Row 0 = 0x8000...0001: only the first and last label pixels light
    run_line(32, 400, -1, -1, -1);
    check("row0_rom_addr_h61", addr_a[61], 0);
    exp_set(0, 1023, 1'b0);
    exp_set(64, 64, 1'b1);
    exp_set(319, 319, 1'b1);
    cmp_line("row0_pattern", 0, 400);
    check("row0_first_px", tx_a[64], 1);
    check("row0_last_px", tx_a[319], 1);
    check("de_out_h0", de_o_a[0], 0);
    check("de_out_h1", de_o_a[1], 1);

    // de_in gap inside the label masks pixels but keeps alignment
    run_line(33, 400, 100, 109, -1);
    check("de_gap_addr_h60", addr_a[60], 0);
    check("de_gap_addr_h61", addr_a[61], 1);
    exp_set(0, 1023, 1'b0);
    exp_set(64, 319, 1'b1);
    exp_set(100, 109, 1'b0);
    cmp_line("de_gap_pattern", 0, 400);
    check("de_gap_last_px", tx_a[319], 1);
    check("de_gap_after_last", tx_a[320], 0);
    check("de_gap_de_out_99", de_o_a[99], 1);
    check("de_gap_de_out_100", de_o_a[100], 0);

    // Lines just outside the label window
    run_line(48, 400, -1, -1, -1);
    exp_set(0, 1023, 1'b0);
    cmp_line("v48_blank", 0, 400);
    addr_changes("v48_no_fetch", 400, 4'd1);
    run_line(31, 400, -1, -1, -1);
    cmp_line("v31_blank", 0, 400);
    addr_changes("v31_no_fetch", 400, 4'd1);

    // Scale x2: row 3 = 0xC000...0 gives four lit pixels
    run_line(38, 600, -1, -1, -1);
    check("scale2_rom_addr", addr_b[61], 3);
    exp_set(0, 1023, 1'b0);
    exp_set(64, 67, 1'b1);
    cmp_line("scale2_pattern", 1, 600);

    // Short line wraps mid-label, next line must restart cleanly
    run_line(33, 200, -1, -1, -1);
    exp_set(0, 1023, 1'b0);
    exp_set(64, 199, 1'b1);
    cmp_line("short_line_pattern", 0, 200);
    run_line(34, 400, -1, -1, -1);
    check("wrap_addr_h60", addr_a[60], 1);
    check("wrap_addr_h61", addr_a[61], 2);
    exp_set(0, 1023, 1'b0);
    exp_set(64, 319, 1'b1);
    cmp_line("wrap_next_pattern", 0, 400);

    // Async reset mid-label, then a normal line
    run_line(35, 400, -1, -1, 150);
    exp_set(0, 1023, 1'b0);
    exp_set(64, 149, 1'b1);
    cmp_line("reset_line_pattern", 0, 400);
    check("reset_line_addr_end", addr_a[399], 0);
    run_line(36, 400, -1, -1, -1);
    check("post_reset_addr", addr_a[61], 4);
    exp_set(0, 1023, 1'b0);
    exp_set(64, 319, 1'b1);
    cmp_line("post_reset_pattern", 0, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
